mux_n_sel_reg: RTL and testbench

Parametrised, registered N-way selector with valid/ready handshakes. It is the successor to the combinational 4:1 datapath mux. It places one of CHANNELS request sources into a single-entry output register. The source is chosen either by an explicit select (MODE 0) or by round-robin arbitration (MODE 1). It sits on shared CPU datapaths, for example where fetch, load/store and writeback sources share one memory or register-file port.

---
 rtl/mux_n_sel_reg.sv | 107 ++++++++++
 tb/tb_mux_n_sel_reg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mux_n_sel_reg.sv
// mux_n_sel_reg
//   Registered N-way selector with valid/ready handshakes. One of CHANNELS
//   request sources is captured into a single-entry output register, chosen
//   by an explicit select (MODE 0) or by round-robin arbitration (MODE 1).
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   n_data     packed channel data, channel k at [k*WIDTH +: WIDTH]
//   n_valid    per-channel request valid
//   n_ready    per-channel accept (at most one bit high)
//   sel        channel select, MODE 0 only
//   res        registered output data
//   res_valid  res holds an unconsumed beat
//   res_chan   index of the channel that produced res
//   res_ready  downstream accepts res this cycle
module mux_n_sel_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] n_data,
  input  logic [CHANNELS-1:0]       n_valid,
  output logic [CHANNELS-1:0]       n_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          res,
  output logic                      res_valid,
  output logic [SEL_W-1:0]          res_chan,
  input  logic                      res_ready
);

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic [SEL_W-1:0] ptr;

  // The output register may be overwritten when empty or being drained
  // in the same cycle, which gives back-to-back beats with no bubble.
  assign load_en = !res_valid || res_ready;

  // Grant selection: channel indices beyond CHANNELS-1 never match, so an
  // out-of-range sel simply yields no grant.
  always_comb begin
    int best_d;
    int d;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    best_d     = CHANNELS;
    d          = 0;
    if (MODE == 0) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (int'(sel) == k && n_valid[k]) begin
          grant_vld  = 1'b1;
          grant_idx  = SEL_W'(k);
          grant_data = n_data[k*WIDTH +: WIDTH];
        end
      end
    end else begin
      // Round robin: the valid channel closest to ptr (going upward,
      // wrapping) wins. ptr is always below CHANNELS.
      for (int k = 0; k < CHANNELS; k++) begin
        d = (k - int'(ptr) + CHANNELS) % CHANNELS;
        if (n_valid[k] && d < best_d) begin
          best_d     = d;
          grant_vld  = 1'b1;
          grant_idx  = SEL_W'(k);
          grant_data = n_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    n_ready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      n_ready[k] = rst_n && load_en && grant_vld && (grant_idx == SEL_W'(k));
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res       <= '0;
      res_valid <= 1'b0;
      res_chan  <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        res       <= grant_data;
        res_chan  <= grant_idx;
        res_valid <= 1'b1;
        if (MODE == 1) begin
          if (grant_idx == SEL_W'(CHANNELS - 1)) ptr <= '0;
          else                                    ptr <= grant_idx + SEL_W'(1);
        end
      end else begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_sel_reg.sv
module tb_mux_n_sel_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // a: MODE 0, 4 channels
  logic [31:0] a_n_data;
  logic [3:0]  a_n_valid, a_n_ready;
  logic [1:0]  a_sel, a_res_chan;
  logic [7:0]  a_res;
  logic        a_res_valid, a_res_ready;
  // b: MODE 0, 3 channels
  logic [23:0] b_n_data;
  logic [2:0]  b_n_valid, b_n_ready;
  logic [1:0]  b_sel, b_res_chan;
  logic [7:0]  b_res;
  logic        b_res_valid, b_res_ready;
  // c: MODE 1, 4 channels
  logic [31:0] c_n_data;
  logic [3:0]  c_n_valid, c_n_ready;
  logic [1:0]  c_sel, c_res_chan;
  logic [7:0]  c_res;
  logic        c_res_valid, c_res_ready;

  mux_n_sel_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .n_data(a_n_data), .n_valid(a_n_valid),
    .n_ready(a_n_ready), .sel(a_sel), .res(a_res), .res_valid(a_res_valid),
    .res_chan(a_res_chan), .res_ready(a_res_ready));

  mux_n_sel_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .n_data(b_n_data), .n_valid(b_n_valid),
    .n_ready(b_n_ready), .sel(b_sel), .res(b_res), .res_valid(b_res_valid),
    .res_chan(b_res_chan), .res_ready(b_res_ready));

  mux_n_sel_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .n_data(c_n_data), .n_valid(c_n_valid),
    .n_ready(c_n_ready), .sel(c_sel), .res(c_res), .res_valid(c_res_valid),
    .res_chan(c_res_chan), .res_ready(c_res_ready));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rr_order [6] = '{1, 3, 0, 1, 3, 0};

  initial begin
    a_n_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b_n_data = {8'hB2, 8'hB1, 8'hB0};
    c_n_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    a_sel = 2'd0; b_sel = 2'd0; c_sel = 2'd0;
    a_n_valid = 4'hF; b_n_valid = 3'h7; c_n_valid = 4'hF;
    a_res_ready = 1'b1; b_res_ready = 1'b1; c_res_ready = 1'b1;
    rst_n = 1'b0;

    // Reset with all requests valid
    tick();
    tick();
    chk("rst_a_res", a_res, 0);
    chk("rst_a_valid", a_res_valid, 0);
    chk("rst_a_chan", a_res_chan, 0);
    chk("rst_a_ready", a_n_ready, 0);
    chk("rst_b_ready", b_n_ready, 0);
    chk("rst_c_res", c_res, 0);
    chk("rst_c_valid", c_res_valid, 0);
    chk("rst_c_ready", c_n_ready, 0);

    // Release; round robin starts at channel 0
    rst_n = 1'b1;
    a_n_valid = 4'h0;
    b_n_valid = 3'h0;
    #1;
    chk("rr_first_ready", c_n_ready, 4'b0001);
    tick();
    chk("rr_first_chan", c_res_chan, 0);
    chk("rr_first_res", c_res, 8'hC0);
    chk("rr_first_valid", c_res_valid, 1);

    // Fairness with channel 2 idle; wraps 3 -> 0
    c_n_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready", c_n_ready, 4'b0001 << rr_order[i]);
      tick();
      chk("rr_chan", c_res_chan, rr_order[i]);
      chk("rr_res", c_res, 8'hC0 + rr_order[i]);
      chk("rr_valid", c_res_valid, 1);
    end
    c_n_valid = 4'b0000;

    // MODE 0 select sweep
    a_n_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      a_sel = 2'(k);
      #1;
      chk("sweep_ready", a_n_ready, 4'b0001 << k);
      tick();
      chk("sweep_res", a_res, 8'hA0 + k);
      chk("sweep_chan", a_res_chan, k);
      chk("sweep_valid", a_res_valid, 1);
    end

    // Backpressure holding a beat from channel 2
    a_sel = 2'd2;
    tick();
    chk("bp_load_chan", a_res_chan, 2);
    a_res_ready = 1'b0;
    a_sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", a_n_ready, 0);
      tick();
      chk("bp_res", a_res, 8'hA2);
      chk("bp_valid", a_res_valid, 1);
      chk("bp_chan", a_res_chan, 2);
    end
    a_res_ready = 1'b1;
    #1;
    chk("bp_release_ready", a_n_ready, 4'b0010);
    tick();
    chk("bp_release_res", a_res, 8'hA1);
    chk("bp_release_chan", a_res_chan, 1);
    chk("bp_release_valid", a_res_valid, 1);

    // Out-of-range select on the 3-channel instance
    b_n_valid = 3'b111;
    b_sel = 2'd1;
    tick();
    chk("inv_pre_res", b_res, 8'hB1);
    chk("inv_pre_valid", b_res_valid, 1);
    b_sel = 2'd3;
    #1;
    chk("inv_ready", b_n_ready, 0);
    tick();
    chk("inv_valid", b_res_valid, 0);
    chk("inv_res_hold", b_res, 8'hB1);
    chk("inv_chan_hold", b_res_chan, 1);

    // Reset mid-stream on the round-robin instance (ptr is 1 here)
    c_n_valid = 4'b1011;
    tick();
    chk("mid_pre_chan", c_res_chan, 1);
    chk("mid_pre_valid", c_res_valid, 1);
    c_res_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", c_n_ready, 0);
    tick();
    chk("mid_rst_valid", c_res_valid, 0);
    chk("mid_rst_res", c_res, 0);
    chk("mid_rst_chan", c_res_chan, 0);
    rst_n = 1'b1;
    c_res_ready = 1'b1;
    #1;
    chk("mid_restart_ready", c_n_ready, 4'b0001);
    tick();
    chk("mid_restart_chan", c_res_chan, 0);
    chk("mid_restart_res", c_res, 8'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
